// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scaler: counts qualified rising trigger edges over a fixed
// gate window on request, then latches the per-beam counts and pulses a done flag.
module beam_trigger_scaler #(
    parameter int NBEAMS         = 2,
    parameter int CNT_WIDTH      = 32,
    parameter int GATE_CYCLES    = 375000,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NBEAMS-1:0]           trigger_i,
    input  logic                        count_req_i,
    output logic                        busy_o,
    output logic [NBEAMS*CNT_WIDTH-1:0] count_o,
    output logic                        count_done_o
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    localparam logic [GATE_W-1:0]    GATE_LOAD = GATE_W'(GATE_CYCLES);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNTING,
        ST_LATCH
    } state_t;

    state_t                      state_q, state_d;
    logic [GATE_W-1:0]           gate_q, gate_d;
    logic [NBEAMS-1:0]           trigger_q, trigger_d;
    logic [HOLD_W-1:0]           hold_q [NBEAMS];
    logic [HOLD_W-1:0]           hold_d [NBEAMS];
    logic [CNT_WIDTH-1:0]        work_q [NBEAMS];
    logic [CNT_WIDTH-1:0]        work_d [NBEAMS];
    logic [NBEAMS*CNT_WIDTH-1:0] count_q, count_d;
    logic                        done_q, done_d;

    logic [NBEAMS-1:0]           edge_det;
    logic [NBEAMS-1:0]           qualified;

    // Edge detection and holdoff run in every state, so the holdoff can span gate boundaries.
    always_comb begin
        trigger_d = trigger_i;
        edge_det  = '0;
        qualified = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            edge_det[b]  = trigger_i[b] & ~trigger_q[b];
            qualified[b] = edge_det[b] && (hold_q[b] == '0);
            hold_d[b]    = hold_q[b];
            if (qualified[b]) begin
                hold_d[b] = HOLD_LOAD;
            end else if (hold_q[b] != '0) begin
                hold_d[b] = hold_q[b] - HOLD_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        count_d = count_q;
        done_d  = 1'b0;
        for (int b = 0; b < NBEAMS; b++) begin
            work_d[b] = work_q[b];
        end

        case (state_q)
            ST_IDLE: begin
                gate_d = GATE_LOAD;
                for (int b = 0; b < NBEAMS; b++) begin
                    work_d[b] = '0;
                end
                if (count_req_i) begin
                    state_d = ST_COUNTING;
                end
            end

            ST_COUNTING: begin
                // Saturating counters: a stuck-toggling trigger must not wrap to a small rate.
                for (int b = 0; b < NBEAMS; b++) begin
                    if (qualified[b] && (work_q[b] != CNT_MAX)) begin
                        work_d[b] = work_q[b] + CNT_WIDTH'(1);
                    end
                end
                gate_d = gate_q - GATE_W'(1);
                if (gate_q == GATE_W'(1)) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                for (int b = 0; b < NBEAMS; b++) begin
                    count_d[b*CNT_WIDTH +: CNT_WIDTH] = work_q[b];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            gate_q    <= '0;
            trigger_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            for (int b = 0; b < NBEAMS; b++) begin
                hold_q[b] <= '0;
                work_q[b] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            trigger_q <= trigger_d;
            count_q   <= count_d;
            done_q    <= done_d;
            for (int b = 0; b < NBEAMS; b++) begin
                hold_q[b] <= hold_d[b];
                work_q[b] <= work_d[b];
            end
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign count_o      = count_q;
    assign count_done_o = done_q;

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Bench for beam_trigger_scaler: table-driven gates, hand-written corner sequences and
// random traffic, all compared every cycle against a timestamp-based reference model.
module tb_beam_trigger_scaler;

    localparam int G = 100;
    localparam int H = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  trig;
    logic        req;
    logic        busy;
    logic [63:0] count;
    logic        done;

    logic [1:0]  trig_sat;
    logic        req_sat;
    logic        busy_sat;
    logic [7:0]  count_sat;
    logic        done_sat;

    always #5 aclk = ~aclk;

    beam_trigger_scaler #(
        .NBEAMS(2), .CNT_WIDTH(32), .GATE_CYCLES(G), .HOLDOFF_CYCLES(H)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .trigger_i(trig), .count_req_i(req),
        .busy_o(busy), .count_o(count), .count_done_o(done)
    );

    // Narrow counters and no holdoff, used only for the saturation sequence.
    beam_trigger_scaler #(
        .NBEAMS(2), .CNT_WIDTH(4), .GATE_CYCLES(G), .HOLDOFF_CYCLES(0)
    ) u_sat (
        .aclk(aclk), .aresetn(aresetn), .trigger_i(trig_sat), .count_req_i(req_sat),
        .busy_o(busy_sat), .count_o(count_sat), .count_done_o(done_sat)
    );

    typedef struct {
        int b0_period;
        int b0_first;
        int b0_x0;
        int b0_x1;
        int b0_x2;
        int b0_x3;
        int b1_rise;
        int b1_x0;
        int b1_x1;
        int b1_x2;
        int b1_x3;
        int req2;
        int exp0;
        int exp1;
    } vec_t;

    vec_t vecs [6];

    int          checks_total  = 0;
    int          checks_passed = 0;

    // Reference model state: cycle index since reset, gate timing and per-beam timestamps.
    int          cyc;
    int          gate_start;
    int          done_cycle;
    int          last_qual [2];
    logic [1:0]  prev_trig;
    logic [31:0] acc [2];
    logic [31:0] exp_count [2];
    logic        exp_busy;

    logic        main_done_now;
    logic [63:0] main_count_now;
    logic        sat_done_now;
    logic        sat_busy_now;
    logic [7:0]  sat_count_now;

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (model cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        cyc        = 0;
        gate_start = -1000;
        done_cycle = -1;
        prev_trig  = 2'b00;
        exp_busy   = 1'b0;
        for (int b = 0; b < 2; b++) begin
            last_qual[b] = -1000;
            acc[b]       = 32'd0;
            exp_count[b] = 32'd0;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic r);
        trig = t;
        req  = r;
    endtask

    task automatic checkOutput();
        if (cyc == done_cycle) begin
            exp_count[0] = acc[0];
            exp_count[1] = acc[1];
        end
        exp_busy = (cyc > gate_start) && (cyc <= gate_start + G + 1);
        expectEq("busy", 64'(busy), 64'(exp_busy));
        expectEq("done", 64'(done), 64'(cyc == done_cycle));
        expectEq("count", count, {exp_count[1], exp_count[0]});
    endtask

    // A qualified edge is one more than H cycles after the previous qualified edge on that beam.
    task automatic modelUpdate(input logic [1:0] t, input logic r);
        for (int b = 0; b < 2; b++) begin
            if (t[b] && !prev_trig[b] && (cyc - last_qual[b] > H)) begin
                last_qual[b] = cyc;
                if ((cyc > gate_start) && (cyc <= gate_start + G) && (acc[b] != 32'hFFFF_FFFF)) begin
                    acc[b] = acc[b] + 32'd1;
                end
            end
        end
        prev_trig = t;
        if (r && !exp_busy) begin
            gate_start = cyc;
            done_cycle = cyc + G + 2;
            acc[0]     = 32'd0;
            acc[1]     = 32'd0;
        end
        cyc++;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic runCycle(input logic [1:0] t, input logic r);
        applyStimulus(t, r);
        @(negedge aclk);
        checkOutput();
        main_done_now  = done;
        main_count_now = count;
        sat_done_now   = done_sat;
        sat_busy_now   = busy_sat;
        sat_count_now  = count_sat;
        modelUpdate(t, r);
        @(posedge aclk);
        #1;
    endtask

    task automatic doReset(input logic [1:0] t);
        aresetn  = 1'b0;
        trig     = t;
        req      = 1'b0;
        trig_sat = 2'b00;
        req_sat  = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        expectEq("rst_busy", 64'(busy), 64'd0);
        expectEq("rst_done", 64'(done), 64'd0);
        expectEq("rst_count", count, 64'd0);
        expectEq("rst_sat_count", 64'(count_sat), 64'd0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        modelReset();
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int dones;
        logic [1:0] t;
        dones = 0;
        for (int c = 0; c <= G + 2; c++) begin
            t[0] = ((v.b0_period > 0) && (c >= v.b0_first) && (c <= G) &&
                    (((c - v.b0_first) % v.b0_period) == 0)) ||
                   (c == v.b0_x0) || (c == v.b0_x1) || (c == v.b0_x2) || (c == v.b0_x3);
            t[1] = ((v.b1_rise >= 0) && (c >= v.b1_rise)) ||
                   (c == v.b1_x0) || (c == v.b1_x1) || (c == v.b1_x2) || (c == v.b1_x3);
            runCycle(t, (c == 0) || (c == v.req2));
            if (main_done_now) dones++;
        end
        expectEq($sformatf("vec%0d_done_pulses", idx), 64'(dones), 64'd1);
        expectEq($sformatf("vec%0d_done_last", idx), 64'(main_done_now), 64'd1);
        expectEq($sformatf("vec%0d_beam0", idx), 64'(main_count_now[31:0]), 64'(v.exp0));
        expectEq($sformatf("vec%0d_beam1", idx), 64'(main_count_now[63:32]), 64'(v.exp1));
        repeat (6) runCycle(2'b00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int dones;
        logic [1:0] rt;

        vecs[0] = '{10, 1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 10, 0};
        vecs[1] = '{0, 0, 5, 8, 9, 20, 3, -1, -1, -1, -1, -1, 2, 1};
        vecs[2] = '{0, 0, 0, 101, -1, -1, -1, 1, 100, -1, -1, -1, 0, 2};
        vecs[3] = '{20, 2, -1, -1, -1, -1, -1, 50, 51, -1, -1, 50, 5, 1};
        vecs[4] = '{6, 4, -1, -1, -1, -1, -1, 4, 10, 16, 22, -1, 17, 4};
        vecs[5] = '{0, 0, 30, 35, -1, -1, -1, 30, 34, -1, -1, -1, 2, 1};

        aresetn  = 1'b0;
        trig     = 2'b00;
        req      = 1'b0;
        trig_sat = 2'b00;
        req_sat  = 1'b0;
        modelReset();
        @(posedge aclk);
        #1;
        doReset(2'b00);
        repeat (4) runCycle(2'b00, 1'b0);

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], i);
        end

        // Saturation: beam0 toggles every cycle (50 edges into a 4-bit counter), beam1 has 7 edges.
        for (int c = 0; c <= G + 2; c++) begin
            trig_sat[0] = (c >= 1) && (c <= 100) && (c % 2 == 1);
            trig_sat[1] = (c >= 1) && (c <= 13) && (c % 2 == 1);
            req_sat     = (c == 0);
            runCycle(2'b00, 1'b0);
            if (c == 50)  expectEq("sat_busy_mid", 64'(sat_busy_now), 64'd1);
            if (c == 101) expectEq("sat_done_early", 64'(sat_done_now), 64'd0);
        end
        expectEq("sat_done", 64'(sat_done_now), 64'd1);
        expectEq("sat_beam0", 64'(sat_count_now[3:0]), 64'd15);
        expectEq("sat_beam1", 64'(sat_count_now[7:4]), 64'd7);
        trig_sat = 2'b00;
        req_sat  = 1'b0;
        repeat (4) runCycle(2'b00, 1'b0);

        // Reset in cycle 40 of a gate must abort it without a done pulse.
        for (int c = 0; c < 40; c++) begin
            runCycle({1'b0, (c % 10 == 1)}, (c == 0));
        end
        doReset(2'b00);
        dones = 0;
        for (int c = 0; c < 110; c++) begin
            runCycle(2'b00, 1'b0);
            if (main_done_now) dones++;
        end
        expectEq("midreset_no_done", 64'(dones), 64'd0);
        expectEq("midreset_count", main_count_now, 64'd0);
        runVector(vecs[0], 6);

        // Random traffic, with one reset taken while triggers may be high.
        rt = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            rt[0] = rt[0] ^ ($urandom_range(0, 3) == 0);
            rt[1] = rt[1] ^ ($urandom_range(0, 3) == 0);
            if (i == 1000) doReset(rt);
            runCycle(rt, ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/beam_trigger_scaler.md
Name: beam_trigger_scaler

Overview:
- Per-beam trigger rate scaler directly downstream of the beamform trigger stage.
- Consumes the per-beam trigger bits and, on request, counts rising trigger edges over a fixed gate window, with a per-beam re-trigger holdoff.
- Latches the counts and pulses a done flag.
- Lives in the aclk domain; its request input and count/done outputs feed the wishbone-side flag_sync and trigger-count readback path.

Parameters:
- NBEAMS, 2, number of beams / trigger bits
- CNT_WIDTH, 32, width of each per-beam count
- GATE_CYCLES, 375000, length of the counting window in aclk cycles (must be ≥1)
- HOLDOFF_CYCLES, 4, cycles after a counted edge during which further edges on that beam are ignored; 0 disables holdoff

Ports:
- aclk  input  1  clock; all logic on rising edge
- aresetn  input  1  synchronous active-low reset
- trigger_i  input  NBEAMS  per-beam trigger bits from the beamformer
- count_req_i  input  1  single-cycle start-of-gate request (already synchronised into aclk)
- busy_o  output  1  high while a gate is in progress (COUNTING or LATCH)
- count_o  output  NBEAMS*CNT_WIDTH  latched per-beam counts; beam b occupies bits [b*CNT_WIDTH +: CNT_WIDTH]
- count_done_o  output  1  one-cycle pulse; count_o is valid from this cycle

Behaviour:
Reset (aresetn low at a clock edge):
- State goes to IDLE.
- Cleared: all working counters, gate counter, holdoff counters and the trigger delay register trigger_q.
- Outputs: count_o = 0, count_done_o = 0, busy_o = 0.
- Reset mid-gate aborts the gate; no done pulse is produced.

Edge detection (every cycle, in every state):
- edge[b] = trigger_i[b] & ~trigger_q[b]; then trigger_q <= trigger_i.
- A trigger held high counts once.
- A trigger already high when reset is released produces an edge on the first cycle after reset.

Holdoff (per beam, every cycle, in every state):
- qualified[b] = edge[b] && (hold[b] == 0).
- If qualified[b], load hold[b] with HOLDOFF_CYCLES; otherwise, if hold[b] != 0, decrement it.
- Edges inside the holdoff are discarded and do not restart the holdoff.
- With HOLDOFF_CYCLES = 4, edges at t and t+5 both count; edges at t and t+4 count once.

FSM states: IDLE, COUNTING, LATCH.
- IDLE:
  - count_req_i = 1 → COUNTING.
  - Load gate counter with GATE_CYCLES.
  - Clear all working counters.
- COUNTING:
  - Each cycle, working counter b increments when qualified[b] is high.
  - Counters saturate at 2^CNT_WIDTH−1; no wrap.
  - Gate counter decrements each cycle; on the cycle it reads 1 → LATCH.
  - Exactly GATE_CYCLES cycles are sampled.
  - count_req_i is ignored.
- LATCH (one cycle):
  - count_o <= working counters; count_done_o <= 1.
  - → IDLE.
  - count_req_i is ignored.

Timing:
- Request sampled at cycle 0 → COUNTING occupies cycles 1..GATE_CYCLES → LATCH at cycle GATE_CYCLES+1.
- count_done_o is high, and new count_o is visible, in cycle GATE_CYCLES+2 only.
- A request arriving in that same cycle (state IDLE) starts a new gate; back-to-back gates are legal.
- count_o holds its value until the next LATCH or reset.
- busy_o = (state != IDLE), registered with the state.
- Simultaneous qualified edges on several beams are all counted independently in the same cycle.

Test Plan (GATE_CYCLES=100, HOLDOFF_CYCLES=4, NBEAMS=2, CNT_WIDTH=32 unless noted):
- Reset behaviour: hold aresetn low 3 cycles, then release with trigger_i=0 → count_o=0, count_done_o=0, busy_o=0.
- Basic count: request at cycle 0; beam0 one-cycle pulses every 10 cycles starting at cycle 1; beam1 held at 0 → done pulse at cycle 102 only, count_o beam0=10, beam1=0; busy_o high for cycles 1–101.
- Holdoff and held-high triggers:
  - Beam0 pulses at gate cycles 5, 8, 9, 20 → count 2.
  - Beam1 held high across the whole gate after rising at cycle 3 → count 1.
- Boundary and overlap:
  - Edge at cycle 0 (the request cycle) and at cycle 101 (LATCH) → neither counted.
  - Edges at cycles 1 and 100 → both counted.
  - Second request at cycle 50 → ignored, single done pulse.
- Saturation: CNT_WIDTH=4, HOLDOFF_CYCLES=0, beam0 toggling every cycle for 100 cycles → beam0 count=15.
- Reset mid-gate: aresetn low at cycle 40 of a gate → no done pulse, count_o stays 0; a new request then behaves as in the basic count test.
